// File: rtl/fnd_pkg.sv
// Shared definitions for the FND display path: count range, count width and
// the run/stop/clear control state encoding.
package fnd_pkg;

    localparam int FND_MAX_COUNT = 9999;
    localparam int FND_COUNT_W   = 14;

    localparam logic [1:0] ST_STOP  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CLEAR = 2'd2;

endpackage

// File: rtl/btn_edge_detect.sv
// Synchronizes one raw (pre-debounced) button and emits a single-clk pulse on
// each press; holding the button produces only the one pulse.
module btn_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic dly;

    // NOTE: non-blocking assignments let every flop sample the previous value
    // of its neighbour, which is what turns these lines into a shift chain.
    // The pulse is registered too, so a press acts three edges after sampling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            dly   <= sync2;
            pulse <= sync2 & ~dly;
        end
    end

endmodule

// File: rtl/updown_count_ctrl.sv
// Run/stop/clear controlled 0..MAX_COUNT up/down counter stepping once per
// tick; feeds the FND controller directly.
module updown_count_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 10,
    parameter int MAX_COUNT = FND_MAX_COUNT,
    parameter int COUNT_W   = FND_COUNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_run,
    input  logic               btn_clear,
    input  logic               btn_mode,
    output logic [COUNT_W-1:0] count,
    output logic               running,
    output logic               mode_down,
    output logic               tick
);

    localparam int                 DIV_N    = CLK_HZ / TICK_HZ;
    localparam int                 DIV_W    = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(DIV_N - 1);
    localparam logic [COUNT_W-1:0] CNT_MAX  = COUNT_W'(MAX_COUNT);

    logic             run_p;
    logic             clear_p;
    logic             mode_p;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [DIV_W-1:0] div;

    btn_edge_detect u_run   (.clk(clk), .rst(rst), .btn(btn_run),   .pulse(run_p));
    btn_edge_detect u_clear (.clk(clk), .rst(rst), .btn(btn_clear), .pulse(clear_p));
    btn_edge_detect u_mode  (.clk(clk), .rst(rst), .btn(btn_mode),  .pulse(mode_p));

    // NOTE: state_nxt gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_STOP: begin
                if (clear_p)    state_nxt = ST_CLEAR;
                else if (run_p) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (clear_p)    state_nxt = ST_CLEAR;
                else if (run_p) state_nxt = ST_STOP;
            end
            ST_CLEAR: state_nxt = ST_STOP;
            default:  state_nxt = ST_STOP;
        endcase
    end

    assign running = (state == ST_RUN);
    assign tick    = running && (div == DIV_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_STOP;
            div       <= '0;
            count     <= '0;
            mode_down <= 1'b0;
        end else begin
            state <= state_nxt;

            // Mode is independent of the FSM; a tick in the same cycle still
            // steps with the old direction because it reads mode_down below.
            if (mode_p) mode_down <= ~mode_down;

            // Any exit from RUN drops the partial period.
            if (running && (state_nxt == ST_RUN) && !tick) div <= div + DIV_W'(1);
            else                                           div <= '0;

            if (state == ST_CLEAR) begin
                count <= '0;
            end else if (tick) begin
                if (mode_down) count <= (count == '0)      ? CNT_MAX : count - COUNT_W'(1);
                else           count <= (count >= CNT_MAX) ? '0      : count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_updown_count_ctrl.sv
// Self-checking bench: a cycle model queues expected outputs at each clk rise,
// the monitor pops and compares them on the falling edge; scenario checks add
// hand-derived constants.
module tb_updown_count_ctrl;

    localparam int DIV_N = 10;

    logic        clk;
    logic        rst;
    logic        btn_run;
    logic        btn_clear;
    logic        btn_mode;
    logic [13:0] count;
    logic        running;
    logic        mode_down;
    logic        tick;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;

    updown_count_ctrl #(
        .CLK_HZ   (100),
        .TICK_HZ  (10),
        .MAX_COUNT(9999),
        .COUNT_W  (14)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_run  (btn_run),
        .btn_clear(btn_clear),
        .btn_mode (btn_mode),
        .count    (count),
        .running  (running),
        .mode_down(mode_down),
        .tick     (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model and scoreboard ----------------
    typedef enum logic [1:0] {M_STOP, M_RUN, M_CLEAR} m_state_t;
    typedef struct packed {
        logic [13:0] count;
        logic        running;
        logic        mode_down;
        logic        tick;
    } exp_t;

    exp_t        sb_q[$];
    logic [3:0]  h_run, h_clr, h_mode;   // [0] = newest clk-edge sample
    m_state_t    m_state, n_state;
    logic [3:0]  m_div, n_div;
    logic [13:0] m_count, n_count;
    logic        m_mode, n_mode;
    logic        p_run, p_clr, p_mode, m_step;

    always_comb begin
        // A press sampled at edge j-3 (after a low sample at j-4) acts at edge j.
        p_run   = h_run[2]  & ~h_run[3];
        p_clr   = h_clr[2]  & ~h_clr[3];
        p_mode  = h_mode[2] & ~h_mode[3];
        m_step  = (m_state == M_RUN) && (m_div == 4'(DIV_N - 1));
        n_count = m_count;
        if (m_state == M_CLEAR)
            n_count = 14'd0;
        else if (m_step && !m_mode)
            n_count = (m_count == 14'd9999) ? 14'd0 : m_count + 14'd1;
        else if (m_step && m_mode)
            n_count = (m_count == 14'd0) ? 14'd9999 : m_count - 14'd1;
        n_mode  = m_mode ^ p_mode;
        n_state = m_state;
        if (m_state == M_CLEAR)  n_state = M_STOP;
        else if (p_clr)          n_state = M_CLEAR;
        else if (p_run)          n_state = (m_state == M_RUN) ? M_STOP : M_RUN;
        n_div   = (m_state == M_RUN && !m_step) ? m_div + 4'd1 : 4'd0;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            h_run   <= '0;
            h_clr   <= '0;
            h_mode  <= '0;
            m_state <= M_STOP;
            m_div   <= '0;
            m_count <= '0;
            m_mode  <= 1'b0;
            sb_q.delete();
        end else begin
            sb_q.push_back('{count: n_count, running: (n_state == M_RUN), mode_down: n_mode,
                             tick: (n_state == M_RUN) && (n_div == 4'(DIV_N - 1))});
            h_run   <= {h_run[2:0],  btn_run};
            h_clr   <= {h_clr[2:0],  btn_clear};
            h_mode  <= {h_mode[2:0], btn_mode};
            m_state <= n_state;
            m_div   <= n_div;
            m_count <= n_count;
            m_mode  <= n_mode;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("cyc_count",     count,     e.count);
            check("cyc_running",   running,   e.running);
            check("cyc_mode_down", mode_down, e.mode_down);
            check("cyc_tick",      tick,      e.tick);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int which, input logic v);
        case (which)
            0:       btn_run   = v;
            1:       btn_clear = v;
            default: btn_mode  = v;
        endcase
    endtask

    task automatic press(input int which, input int hold);
        drive(which, 1'b1);
        repeat (hold) @(posedge clk);
        #1;
        drive(which, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count",     count,     0);
        check("rst_running",   running,   0);
        check("rst_mode_down", mode_down, 0);
        check("rst_tick",      tick,      0);
        @(negedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input string tag, input int exp, output int n);
        logic [13:0] old;
        old = count;
        n   = 0;
        while (count == old && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (count == old) check({tag, "_timeout"}, 0, 1);
        else              check(tag, count, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        btn_mode  = 1'b0;
        rst       = 1'b1;
        do_reset();

        // 1: run press held 20 clk, latency and first three ticks
        btn_run = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("s1_running_k2", running, 0);
        @(posedge clk);
        #1 check("s1_running_k3", running, 1);
        repeat (9) @(posedge clk);
        #1 check("s1_tick_9", tick, 1);
        check("s1_count_9", count, 0);
        @(posedge clk);
        #1 check("s1_count_10", count, 1);
        check("s1_tick_10", tick, 0);
        repeat (7) @(posedge clk);
        #1 btn_run = 1'b0;
        repeat (13) @(posedge clk);
        #1 check("s1_count_30", count, 3);
        check("s1_still_running", running, 1);

        // 2: down through 0 to 9998, then up-wrap and down-wrap at 9999/0
        press(2, 4);
        check("s2_mode_down", mode_down, 1);
        wait_step("s2_dn_2", 2, cyc);
        wait_step("s2_dn_1", 1, cyc);
        wait_step("s2_dn_0", 0, cyc);
        wait_step("s2_dn_9999", 9999, cyc);
        wait_step("s2_dn_9998", 9998, cyc);
        press(2, 4);
        check("s2_mode_up", mode_down, 0);
        wait_step("s2_up_9999", 9999, cyc);
        wait_step("s2_up_wrap0", 0, cyc);
        press(2, 4);
        wait_step("s2_dn_wrap", 9999, cyc);

        // 3: mode then run from reset
        do_reset();
        press(2, 4);
        check("s3_mode_down", mode_down, 1);
        press(0, 4);
        check("s3_running", running, 1);
        wait_step("s3_first", 9999, cyc);
        check("s3_first_cycles", cyc, 10);
        wait_step("s3_second", 9998, cyc);
        check("s3_second_cycles", cyc, 10);

        // 4: run and clear together at count 5
        do_reset();
        press(0, 4);
        for (int i = 1; i <= 5; i++) wait_step("s4_up", i, cyc);
        btn_run   = 1'b1;
        btn_clear = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("s4_clear_running", running, 0);
        check("s4_clear_count_held", count, 5);
        @(posedge clk);
        #1 check("s4_stop_count", count, 0);
        check("s4_stop_running", running, 0);
        btn_run   = 1'b0;
        btn_clear = 1'b0;
        repeat (30) @(posedge clk);
        #1 check("s4_idle_count", count, 0);
        check("s4_idle_running", running, 0);

        // 5: stop at divider 6, restart gets a full period
        do_reset();
        press(0, 4);
        wait_step("s5_first", 1, cyc);
        check("s5_first_cycles", cyc, 10);
        repeat (3) @(posedge clk);
        #1 btn_run = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("s5_stopped", running, 0);
        btn_run = 1'b0;
        repeat (20) @(posedge clk);
        #1 check("s5_count_kept", count, 1);
        press(0, 4);
        check("s5_restarted", running, 1);
        wait_step("s5_restart_step", 2, cyc);
        check("s5_restart_cycles", cyc, 10);

        // 6: async reset mid-RUN at count 42, mode down
        do_reset();
        press(0, 4);
        for (int i = 1; i <= 42; i++) wait_step("s6_up", i, cyc);
        press(2, 4);
        check("s6_pre_mode", mode_down, 1);
        check("s6_pre_count", count, 42);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("s6_async_count",     count,     0);
        check("s6_async_running",   running,   0);
        check("s6_async_mode_down", mode_down, 0);
        check("s6_async_tick",      tick,      0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (15) @(posedge clk);
        #1 check("s6_post_running", running, 0);
        check("s6_post_count", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
